fpu_mmio_responder: RTL and testbench
=====================================

Name: fpu_mmio_responder

Overview:
Memory-mapped slave that answers the CPU-side FPU register protocol. It decodes the 16-byte word window at BASE_ADDR (FPU_CMD at 0xFFE0, FPU_STATUS at 0xFFE2, and the registers that follow). A command write is turned into a one-cycle instruction dispatch to the FPU core. The block tracks completion, stages 80-bit operands and results, and raises a completion interrupt. It sits between the CPU bus master and FPU_System_Integration.

Parameters:
BASE_ADDR, 20'hFFE0, base of the register window; a 16-byte window is decoded.
START_TIMEOUT, 8, cycles to wait for fpu_busy to rise after dispatch before treating the op as complete.
CTRL_RESET, 16'h037F, reset value of the control word.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  20  byte address from the bus master
cpu_data_in  in  16  write data
cpu_data_out  out  16  read data; valid while cpu_ack=1
cpu_access  in  1  request; held high until acked
cpu_wr_en  in  1  1=write, 0=read
cpu_bytesel  in  2  00 or 11=word, 01=low byte only, 10=high byte only
cpu_ack  out  1  one-cycle acknowledge
fpu_opcode  out  8  dispatched opcode
fpu_modrm  out  8  dispatched ModR/M
fpu_instruction_valid  out  1  one-cycle dispatch strobe
fpu_busy  in  1  FPU core busy
fpu_int  in  1  FPU exception interrupt
fpu_data_to_fpu  out  80  staged operand
fpu_data_from_fpu  in  80  FPU result
fpu_control_word  out  16  control word register
fpu_status_word  in  16  FPU status word
cpu_irq  out  1  interrupt to CPU

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 CMD: write {modrm,opcode}; read returns the last command.
  - 0x2 STATUS: read-only; returns {fpu_busy|eng_busy, fpu_status_word[14:0]}.
  - 0x4 CONTROL: read/write.
  - 0x6/0x8/0xA/0xC/0xE DATA0..DATA4: writes fill operand bits [15:0]..[79:64]; reads return the latched result. DATA4 reads return 16 bits, with bits 79:64 on [15:0].
  - Writes to STATUS are acked with no effect.
- ERR/CFG register at offset 0x10, decoded as an extension of the window:
  - bit0 OVERRUN, bit1 NONESC, bit2 DONE: sticky, write-1-to-clear.
  - bit8 IRQ_EN: read/write, reset 0.
- Bus handshake:
  - cpu_access sampled high with an in-window address in cycle N produces cpu_ack=1 in cycle N+1, with cpu_data_out valid.
  - Write side effects commit at the N+1 edge.
  - Access is ignored during the ack cycle, so the minimum spacing is 2 cycles.
  - Out-of-window addresses get no ack, no side effect, and cpu_data_out=0.
- Byte lanes apply to CONTROL, DATA and ERR. CMD always takes the full word.
- Dispatch FSM: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> CAPTURE -> IDLE. eng_busy = (state != IDLE).
  - IDLE: a CMD write with opcode[7:3]==5'b11011 latches fpu_opcode/fpu_modrm and goes to ISSUE.
  - CMD write with a non-ESC opcode: set NONESC, no dispatch.
  - CMD write while eng_busy: set OVERRUN, command discarded, the latched opcode is unchanged.
  - ISSUE: fpu_instruction_valid=1 for exactly one cycle, then WAIT_START with a counter cleared.
  - WAIT_START: fpu_busy=1 goes to WAIT_DONE. Counter reaching START_TIMEOUT goes to CAPTURE (single-cycle op).
  - WAIT_DONE: fpu_busy=0 goes to CAPTURE.
  - CAPTURE: latch fpu_data_from_fpu into the result register, set DONE, go to IDLE.
- cpu_irq = fpu_int | (DONE & IRQ_EN). Combinational OR of registered terms.
- Simultaneous events:
  - A W1C to DONE in the same cycle as CAPTURE leaves DONE=1 (set wins).
  - A DATA write while busy updates the operand staging only; fpu_data_to_fpu is not frozen.
- Reset (asynchronous, any state, including mid-op), all outputs and registers return to:
  - FSM IDLE, cpu_ack=0, cpu_data_out=0, fpu_instruction_valid=0.
  - fpu_opcode/fpu_modrm=0, operand and result=0.
  - fpu_control_word=CTRL_RESET, ERR=0, cpu_irq=fpu_int.

Test Plan:
- Reset, read CONTROL (0xFFE4) -> ack 1 cycle later, data 0x037F; read 0xFFE2 with fpu_status_word=0x0000 -> 0x0000.
- Write CMD 0xFFE0=0xC1D8, fpu_busy high 3 cycles after strobe for 10 cycles, fpu_data_from_fpu=80'h3FFF8000000000000000 -> opcode D8, modrm C1, one strobe; STATUS bit15=1 during the op; then ERR bit2=1 and DATA4 read=0x3FFF.
- Second CMD write while busy -> acked, no second strobe, ERR read=0x0001; write 0x0001 to ERR -> reads 0x0000.
- CMD 0x0090 (non-ESC) -> no strobe, ERR bit1 set. CMD 0xC0D9 with fpu_busy never rising -> CAPTURE after 8 cycles, DONE set.
- IRQ_EN=1, complete an op -> cpu_irq=1; W1C DONE -> cpu_irq=0. Read 0xFFF2 -> no ack. Deassert reset_n during WAIT_DONE -> FSM IDLE and outputs at reset values immediately.

Source files
------------

// File: rtl/fpu_mmio_responder_if.sv
// CPU-side register bus between the bus master and fpu_mmio_responder.
//   cpu_addr     byte address of the access
//   cpu_data_in  write data
//   cpu_data_out read data, valid while cpu_ack=1
//   cpu_access   request, held by the master until acked
//   cpu_wr_en    1=write, 0=read
//   cpu_bytesel  00/11=word, 01=low byte, 10=high byte
//   cpu_ack      one-cycle acknowledge from the slave
interface fpu_mmio_responder_if;
   logic [19:0] cpu_addr;
   logic [15:0] cpu_data_in;
   logic [15:0] cpu_data_out;
   logic        cpu_access;
   logic        cpu_wr_en;
   logic [1:0]  cpu_bytesel;
   logic        cpu_ack;

   modport master (
      output cpu_addr, cpu_data_in, cpu_access, cpu_wr_en, cpu_bytesel,
      input  cpu_data_out, cpu_ack
   );

   modport slave (
      input  cpu_addr, cpu_data_in, cpu_access, cpu_wr_en, cpu_bytesel,
      output cpu_data_out, cpu_ack
   );
endinterface

// File: rtl/fpu_mmio_responder.sv
// Memory-mapped front end for the FPU core. Decodes the word registers at
// BASE_ADDR (CMD, STATUS, CONTROL, DATA0..DATA4, ERR/CFG), turns an ESC
// command write into a one-cycle dispatch, tracks completion of the op,
// stages the 80-bit operand, captures the 80-bit result and raises cpu_irq.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   bus                     CPU register bus (slave side)
//   fpu_opcode/fpu_modrm    latched dispatched instruction bytes
//   fpu_instruction_valid   one-cycle dispatch strobe
//   fpu_busy, fpu_int       core busy and exception interrupt
//   fpu_data_to_fpu         staged operand
//   fpu_data_from_fpu       core result, captured at completion
//   fpu_control_word        CONTROL register
//   fpu_status_word         core status, visible through STATUS
//   cpu_irq                 interrupt to the CPU
module fpu_mmio_responder #(
   parameter logic [19:0] BASE_ADDR     = 20'hFFE0,
   parameter int          START_TIMEOUT = 8,
   parameter logic [15:0] CTRL_RESET    = 16'h037F
) (
   input  logic                  clk,
   input  logic                  reset_n,
   fpu_mmio_responder_if.slave   bus,
   output logic [7:0]            fpu_opcode,
   output logic [7:0]            fpu_modrm,
   output logic                  fpu_instruction_valid,
   input  logic                  fpu_busy,
   input  logic                  fpu_int,
   output logic [79:0]           fpu_data_to_fpu,
   input  logic [79:0]           fpu_data_from_fpu,
   output logic [15:0]           fpu_control_word,
   input  logic [15:0]           fpu_status_word,
   output logic                  cpu_irq
);

   localparam int NUM_DATA = 5;
   localparam int CW       = $clog2(START_TIMEOUT + 1);

   // Word offsets within the window; ERR sits just past the 16-byte block.
   localparam logic [3:0] W_CMD   = 4'h0;
   localparam logic [3:0] W_STAT  = 4'h1;
   localparam logic [3:0] W_CTRL  = 4'h2;
   localparam logic [3:0] W_DATA0 = 4'h3;
   localparam logic [3:0] W_ERR   = 4'h8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_WSTART = 3'd2;
   localparam logic [2:0] S_WDONE  = 3'd3;
   localparam logic [2:0] S_CAPT   = 3'd4;

   logic [2:0]                 state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [7:0]                 opcode_q, opcode_d;
   logic [7:0]                 modrm_q, modrm_d;
   logic [15:0]                ctrl_q, ctrl_d;
   logic [NUM_DATA-1:0][15:0]  operand_q, operand_d;
   logic [NUM_DATA-1:0][15:0]  result_q, result_d;
   logic                       ovr_q, ovr_d;
   logic                       nonesc_q, nonesc_d;
   logic                       done_q, done_d;
   logic                       irq_en_q, irq_en_d;
   logic                       ack_q;
   logic [15:0]                rdata_q, rdata_d;

   logic [18:0] woff;
   logic [3:0]  word;
   logic        in_win, accept, wr, lane_lo, lane_hi, eng_busy, is_esc;

   function automatic logic [15:0] merge(input logic [15:0] old_v,
                                         input logic [15:0] new_v,
                                         input logic lo, input logic hi);
      merge = {hi ? new_v[15:8] : old_v[15:8], lo ? new_v[7:0] : old_v[7:0]};
   endfunction

   // Decode in word units; an address below BASE_ADDR wraps to a large
   // offset and so falls outside the window.
   assign woff    = bus.cpu_addr[19:1] - BASE_ADDR[19:1];
   assign in_win  = (woff <= 19'd8);
   assign word    = woff[3:0];
   // No new access is taken in the ack cycle.
   assign accept  = bus.cpu_access & in_win & ~ack_q;
   assign wr      = accept & bus.cpu_wr_en;
   assign lane_lo = (bus.cpu_bytesel != 2'b10);
   assign lane_hi = (bus.cpu_bytesel != 2'b01);
   assign eng_busy = (state_q != S_IDLE);
   assign is_esc  = (bus.cpu_data_in[7:3] == 5'b11011);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opcode_d  = opcode_q;
      modrm_d   = modrm_q;
      ctrl_d    = ctrl_q;
      operand_d = operand_q;
      result_d  = result_q;
      ovr_d     = ovr_q;
      nonesc_d  = nonesc_q;
      done_d    = done_q;
      irq_en_d  = irq_en_q;

      // Register writes. CMD ignores byte lanes.
      if (wr) begin
         case (word)
            W_CMD: begin
               if (eng_busy) begin
                  ovr_d = 1'b1;
               end else if (!is_esc) begin
                  nonesc_d = 1'b1;
               end else begin
                  opcode_d = bus.cpu_data_in[7:0];
                  modrm_d  = bus.cpu_data_in[15:8];
                  state_d  = S_ISSUE;
               end
            end
            W_CTRL: ctrl_d = merge(ctrl_q, bus.cpu_data_in, lane_lo, lane_hi);
            W_ERR: begin
               if (lane_lo) begin
                  if (bus.cpu_data_in[0]) ovr_d    = 1'b0;
                  if (bus.cpu_data_in[1]) nonesc_d = 1'b0;
                  if (bus.cpu_data_in[2]) done_d   = 1'b0;
               end
               if (lane_hi) irq_en_d = bus.cpu_data_in[8];
            end
            default: ;
         endcase
      end

      // Operand staging stays writable while the engine runs.
      for (int k = 0; k < NUM_DATA; k++) begin
         if (wr && (word == W_DATA0 + 4'(k)))
            operand_d[k] = merge(operand_q[k], bus.cpu_data_in, lane_lo, lane_hi);
      end

      // Dispatch engine. Evaluated after the ERR write so a completion
      // in the same cycle as a DONE clear leaves DONE set.
      case (state_q)
         S_ISSUE: begin
            state_d = S_WSTART;
            cnt_d   = '0;
         end
         S_WSTART: begin
            if (fpu_busy) begin
               state_d = S_WDONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               // Core never raised busy: treat as a single-cycle op.
               if (cnt_d == CW'(START_TIMEOUT)) state_d = S_CAPT;
            end
         end
         S_WDONE: if (!fpu_busy) state_d = S_CAPT;
         S_CAPT: begin
            result_d = fpu_data_from_fpu;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: ;
      endcase
   end

   // Read data is registered with the ack and forced to zero otherwise.
   always_comb begin
      rdata_d = 16'h0000;
      if (accept) begin
         case (word)
            W_CMD:  rdata_d = {modrm_q, opcode_q};
            W_STAT: rdata_d = {fpu_busy | eng_busy, fpu_status_word[14:0]};
            W_CTRL: rdata_d = ctrl_q;
            W_ERR:  rdata_d = {7'b0, irq_en_q, 5'b0, done_q, nonesc_q, ovr_q};
            default: begin
               for (int k = 0; k < NUM_DATA; k++)
                  if (word == W_DATA0 + 4'(k)) rdata_d = result_q[k];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         opcode_q  <= 8'h00;
         modrm_q   <= 8'h00;
         ctrl_q    <= CTRL_RESET;
         operand_q <= '0;
         result_q  <= '0;
         ovr_q     <= 1'b0;
         nonesc_q  <= 1'b0;
         done_q    <= 1'b0;
         irq_en_q  <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opcode_q  <= opcode_d;
         modrm_q   <= modrm_d;
         ctrl_q    <= ctrl_d;
         operand_q <= operand_d;
         result_q  <= result_d;
         ovr_q     <= ovr_d;
         nonesc_q  <= nonesc_d;
         done_q    <= done_d;
         irq_en_q  <= irq_en_d;
         ack_q     <= accept;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.cpu_ack           = ack_q;
   assign bus.cpu_data_out      = rdata_q;
   assign fpu_opcode            = opcode_q;
   assign fpu_modrm             = modrm_q;
   assign fpu_instruction_valid = (state_q == S_ISSUE);
   assign fpu_data_to_fpu       = operand_q;
   assign fpu_control_word      = ctrl_q;
   assign cpu_irq               = fpu_int | (done_q & irq_en_q);

endmodule

// File: tb/tb_fpu_mmio_responder.sv
module tb_fpu_mmio_responder;
   localparam logic [19:0] A_CMD  = 20'hFFE0;
   localparam logic [19:0] A_STAT = 20'hFFE2;
   localparam logic [19:0] A_CTRL = 20'hFFE4;
   localparam logic [19:0] A_D0   = 20'hFFE6;
   localparam logic [19:0] A_D1   = 20'hFFE8;
   localparam logic [19:0] A_D2   = 20'hFFEA;
   localparam logic [19:0] A_D3   = 20'hFFEC;
   localparam logic [19:0] A_D4   = 20'hFFEE;
   localparam logic [19:0] A_ERR  = 20'hFFF0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [7:0]  fpu_opcode, fpu_modrm;
   logic        fpu_instruction_valid;
   logic        fpu_busy = 1'b0;
   logic        fpu_int = 1'b0;
   logic [79:0] fpu_data_to_fpu;
   logic [79:0] fpu_data_from_fpu = '0;
   logic [15:0] fpu_control_word;
   logic [15:0] fpu_status_word = 16'h0000;
   logic        cpu_irq;

   int total = 0;
   int bad = 0;
   int strobes = 0;
   logic [7:0] last_op = 8'h00;
   logic [7:0] last_modrm = 8'h00;

   always #5 clk = ~clk;

   fpu_mmio_responder_if ifc();

   fpu_mmio_responder dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .bus                   (ifc),
      .fpu_opcode            (fpu_opcode),
      .fpu_modrm             (fpu_modrm),
      .fpu_instruction_valid (fpu_instruction_valid),
      .fpu_busy              (fpu_busy),
      .fpu_int               (fpu_int),
      .fpu_data_to_fpu       (fpu_data_to_fpu),
      .fpu_data_from_fpu     (fpu_data_from_fpu),
      .fpu_control_word      (fpu_control_word),
      .fpu_status_word       (fpu_status_word),
      .cpu_irq               (cpu_irq)
   );

   always @(negedge clk) begin
      if (fpu_instruction_valid) begin
         strobes++;
         last_op    = fpu_opcode;
         last_modrm = fpu_modrm;
      end
   end

   // One bus transfer: request sampled at the next rising edge, result
   // taken 1ns later, then the ack cycle is let through.
   task automatic xfer(input logic [19:0] a, input logic w, input logic [15:0] d,
                       input logic [1:0] bs, output logic [15:0] rd, output logic ak);
      @(negedge clk);
      ifc.cpu_addr = a; ifc.cpu_wr_en = w; ifc.cpu_data_in = d;
      ifc.cpu_bytesel = bs; ifc.cpu_access = 1'b1;
      @(posedge clk); #1;
      ak = ifc.cpu_ack; rd = ifc.cpu_data_out;
      ifc.cpu_access = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_reset;
      logic [15:0] rd; logic ak;
      #2 reset_n = 1'b0;
      #1;
      total++; if (ifc.cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got %b want 0", ifc.cpu_ack); end
      total++; if (ifc.cpu_data_out !== 16'h0) begin bad++; $display("FAIL rst_dout got %h want 0000", ifc.cpu_data_out); end
      total++; if (fpu_instruction_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", fpu_instruction_valid); end
      total++; if ({fpu_modrm, fpu_opcode} !== 16'h0) begin bad++; $display("FAIL rst_cmd got %h want 0000", {fpu_modrm, fpu_opcode}); end
      total++; if (fpu_data_to_fpu !== 80'h0) begin bad++; $display("FAIL rst_operand got %h want 0", fpu_data_to_fpu); end
      total++; if (fpu_control_word !== 16'h037F) begin bad++; $display("FAIL rst_ctrl got %h want 037f", fpu_control_word); end
      fpu_int = 1'b1; #1;
      total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL rst_irq_int got %b want 1", cpu_irq); end
      fpu_int = 1'b0; #1;
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got %b want 0", cpu_irq); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      xfer(A_CTRL, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (ak !== 1'b1 || rd !== 16'h037F) begin bad++; $display("FAIL read_ctrl got ack=%b %h want ack=1 037f", ak, rd); end
      xfer(A_STAT, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (ak !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL read_stat0 got ack=%b %h want ack=1 0000", ak, rd); end
      fpu_status_word = 16'hC234;
      xfer(A_STAT, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h4234) begin bad++; $display("FAIL read_stat_bit15 got %h want 4234", rd); end
      fpu_status_word = 16'h0000;
      xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (ak !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL read_err_rst got ack=%b %h want ack=1 0000", ak, rd); end
   endtask

   task automatic test_dispatch;
      logic [15:0] rd, r_stat, r_err1, r_err2; logic ak, ak_ovr;
      int s0, n;
      s0 = strobes;
      fpu_data_from_fpu = 80'h3FFF8000000000000000;
      xfer(A_CMD, 1'b1, 16'hC1D8, 2'b11, rd, ak);
      fork
         begin
            repeat (2) @(posedge clk); #1 fpu_busy = 1'b1;
            repeat (10) @(posedge clk); #1 fpu_busy = 1'b0;
         end
         begin
            xfer(A_STAT, 1'b0, 16'h0, 2'b11, r_stat, ak);
            xfer(A_CMD, 1'b1, 16'hC0D9, 2'b11, rd, ak_ovr);
            xfer(A_ERR, 1'b0, 16'h0, 2'b11, r_err1, ak);
            xfer(A_ERR, 1'b1, 16'h0001, 2'b11, rd, ak);
            xfer(A_ERR, 1'b0, 16'h0, 2'b11, r_err2, ak);
         end
      join
      total++; if (r_stat !== 16'h8000) begin bad++; $display("FAIL stat_busy got %h want 8000", r_stat); end
      total++; if (ak_ovr !== 1'b1) begin bad++; $display("FAIL ovr_ack got %b want 1", ak_ovr); end
      total++; if (r_err1 !== 16'h0001) begin bad++; $display("FAIL err_overrun got %h want 0001", r_err1); end
      total++; if (r_err2 !== 16'h0000) begin bad++; $display("FAIL err_w1c got %h want 0000", r_err2); end
      n = 0;
      do begin xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak); n++; end while (!rd[2] && n < 30);
      total++; if (rd !== 16'h0004) begin bad++; $display("FAIL dispatch_done got %h want 0004", rd); end
      total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL strobe_count got %0d want 1", strobes - s0); end
      total++; if ({last_modrm, last_op} !== 16'hC1D8) begin bad++; $display("FAIL strobe_cmd got %h want c1d8", {last_modrm, last_op}); end
      total++; if ({fpu_modrm, fpu_opcode} !== 16'hC1D8) begin bad++; $display("FAIL latched_cmd got %h want c1d8", {fpu_modrm, fpu_opcode}); end
      xfer(A_D4, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h3FFF) begin bad++; $display("FAIL data4 got %h want 3fff", rd); end
      xfer(A_D3, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h8000) begin bad++; $display("FAIL data3 got %h want 8000", rd); end
      xfer(A_CMD, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'hC1D8) begin bad++; $display("FAIL read_cmd got %h want c1d8", rd); end
      xfer(A_ERR, 1'b1, 16'h0007, 2'b11, rd, ak);
   endtask

   task automatic test_nonesc_timeout;
      logic [15:0] rd; logic ak;
      int s0, n;
      s0 = strobes;
      xfer(A_CMD, 1'b1, 16'h0090, 2'b11, rd, ak);
      xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h0002) begin bad++; $display("FAIL nonesc_err got %h want 0002", rd); end
      total++; if (strobes !== s0 || fpu_opcode !== 8'hD8) begin bad++; $display("FAIL nonesc_nodispatch got strobes=%0d op=%h want %0d d8", strobes, fpu_opcode, s0); end
      xfer(A_ERR, 1'b1, 16'h0002, 2'b11, rd, ak);
      fpu_data_from_fpu = 80'h123456789ABCDEF01357;
      xfer(A_CMD, 1'b1, 16'hC0D9, 2'b11, rd, ak);
      repeat (3) xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h0000) begin bad++; $display("FAIL timeout_early got %h want 0000", rd); end
      n = 0;
      do begin xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak); n++; end while (!rd[2] && n < 8);
      total++; if (rd !== 16'h0004) begin bad++; $display("FAIL timeout_done got %h want 0004", rd); end
      total++; if (strobes - s0 !== 1 || last_op !== 8'hD9 || last_modrm !== 8'hC0) begin bad++; $display("FAIL timeout_strobe got n=%0d %h%h want 1 c0d9", strobes - s0, last_modrm, last_op); end
      xfer(A_D0, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h1357) begin bad++; $display("FAIL timeout_data0 got %h want 1357", rd); end
      xfer(A_D2, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h9ABC) begin bad++; $display("FAIL timeout_data2 got %h want 9abc", rd); end
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL irq_masked got %b want 0", cpu_irq); end
      xfer(A_ERR, 1'b1, 16'h0004, 2'b11, rd, ak);
   endtask

   task automatic test_irq;
      logic [15:0] rd; logic ak;
      int n;
      xfer(A_ERR, 1'b1, 16'h0100, 2'b10, rd, ak);
      xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h0100 || cpu_irq !== 1'b0) begin bad++; $display("FAIL irq_en_set got %h irq=%b want 0100 irq=0", rd, cpu_irq); end
      xfer(A_CMD, 1'b1, 16'hC0D9, 2'b11, rd, ak);
      n = 0;
      do begin xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak); n++; end while (!rd[2] && n < 15);
      total++; if (rd !== 16'h0104 || cpu_irq !== 1'b1) begin bad++; $display("FAIL irq_done got %h irq=%b want 0104 irq=1", rd, cpu_irq); end
      // Low-lane-only clear: IRQ_EN in the high byte must survive.
      xfer(A_ERR, 1'b1, 16'h0004, 2'b01, rd, ak);
      xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h0100 || cpu_irq !== 1'b0) begin bad++; $display("FAIL irq_clear got %h irq=%b want 0100 irq=0", rd, cpu_irq); end
      fpu_int = 1'b1; #1;
      total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL irq_fpu_int got %b want 1", cpu_irq); end
      fpu_int = 1'b0;
      xfer(A_ERR, 1'b1, 16'h0000, 2'b11, rd, ak);
   endtask

   task automatic test_bytelanes;
      logic [15:0] rd; logic ak;
      xfer(A_CTRL, 1'b1, 16'h1234, 2'b00, rd, ak);
      xfer(A_CTRL, 1'b1, 16'hABCD, 2'b01, rd, ak);
      xfer(A_CTRL, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h12CD) begin bad++; $display("FAIL ctrl_lo got %h want 12cd", rd); end
      xfer(A_CTRL, 1'b1, 16'h5678, 2'b10, rd, ak);
      total++; if (fpu_control_word !== 16'h56CD) begin bad++; $display("FAIL ctrl_hi got %h want 56cd", fpu_control_word); end
      xfer(A_D0, 1'b1, 16'h1111, 2'b11, rd, ak);
      xfer(A_D1, 1'b1, 16'h2222, 2'b11, rd, ak);
      xfer(A_D2, 1'b1, 16'h3333, 2'b11, rd, ak);
      xfer(A_D3, 1'b1, 16'h4444, 2'b11, rd, ak);
      xfer(A_D4, 1'b1, 16'h5555, 2'b11, rd, ak);
      total++; if (fpu_data_to_fpu !== 80'h55554444333322221111) begin bad++; $display("FAIL operand got %h want 55554444333322221111", fpu_data_to_fpu); end
      xfer(A_D2, 1'b1, 16'hAB00, 2'b10, rd, ak);
      total++; if (fpu_data_to_fpu !== 80'h55554444AB3322221111) begin bad++; $display("FAIL operand_hi got %h want 55554444ab3322221111", fpu_data_to_fpu); end
   endtask

   task automatic test_window;
      logic [15:0] rd; logic ak;
      xfer(20'hFFF2, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (ak !== 1'b0 || rd !== 16'h0000) begin bad++; $display("FAIL oow_read got ack=%b %h want ack=0 0000", ak, rd); end
      xfer(20'hEFFE4, 1'b1, 16'hBEEF, 2'b11, rd, ak);
      total++; if (ak !== 1'b0) begin bad++; $display("FAIL oow_alias_ack got %b want 0", ak); end
      xfer(20'hFFDE, 1'b1, 16'hDEAD, 2'b11, rd, ak);
      total++; if (ak !== 1'b0 || fpu_control_word !== 16'h56CD) begin bad++; $display("FAIL oow_write got ack=%b ctrl=%h want 0 56cd", ak, fpu_control_word); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      ifc.cpu_addr = A_CTRL; ifc.cpu_wr_en = 1'b0; ifc.cpu_bytesel = 2'b11; ifc.cpu_access = 1'b1;
      @(posedge clk); #1;
      total++; if (ifc.cpu_ack !== 1'b1 || ifc.cpu_data_out !== 16'h56CD) begin bad++; $display("FAIL b2b_first got ack=%b %h want 1 56cd", ifc.cpu_ack, ifc.cpu_data_out); end
      @(posedge clk); #1;
      total++; if (ifc.cpu_ack !== 1'b0 || ifc.cpu_data_out !== 16'h0000) begin bad++; $display("FAIL b2b_gap got ack=%b %h want 0 0000", ifc.cpu_ack, ifc.cpu_data_out); end
      @(posedge clk); #1;
      total++; if (ifc.cpu_ack !== 1'b1) begin bad++; $display("FAIL b2b_second got ack=%b want 1", ifc.cpu_ack); end
      ifc.cpu_access = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_collisions;
      logic [15:0] rd; logic ak;
      fpu_busy = 1'b1;
      xfer(A_CMD, 1'b1, 16'hC1D8, 2'b11, rd, ak);
      xfer(A_D1, 1'b1, 16'hBEEF, 2'b11, rd, ak);
      total++; if (fpu_data_to_fpu[31:16] !== 16'hBEEF) begin bad++; $display("FAIL data_while_busy got %h want beef", fpu_data_to_fpu[31:16]); end
      // Drop busy so the DONE clear commits on the capture edge.
      @(negedge clk); fpu_busy = 1'b0;
      @(posedge clk);
      xfer(A_ERR, 1'b1, 16'h0004, 2'b11, rd, ak);
      xfer(A_ERR, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h0004) begin bad++; $display("FAIL done_set_wins got %h want 0004", rd); end
      xfer(A_ERR, 1'b1, 16'h0004, 2'b11, rd, ak);
   endtask

   task automatic test_reset_midop;
      logic [15:0] rd; logic ak;
      fpu_busy = 1'b1;
      xfer(A_CMD, 1'b1, 16'hC1D8, 2'b11, rd, ak);
      repeat (3) @(posedge clk);
      @(negedge clk); #2 reset_n = 1'b0; #1;
      total++; if (fpu_instruction_valid !== 1'b0 || {fpu_modrm, fpu_opcode} !== 16'h0) begin bad++; $display("FAIL midrst_cmd got v=%b %h want 0 0000", fpu_instruction_valid, {fpu_modrm, fpu_opcode}); end
      total++; if (fpu_data_to_fpu !== 80'h0 || fpu_control_word !== 16'h037F) begin bad++; $display("FAIL midrst_regs got %h %h want 0 037f", fpu_data_to_fpu, fpu_control_word); end
      total++; if (ifc.cpu_ack !== 1'b0 || ifc.cpu_data_out !== 16'h0 || cpu_irq !== 1'b0) begin bad++; $display("FAIL midrst_bus got ack=%b %h irq=%b want 0 0000 0", ifc.cpu_ack, ifc.cpu_data_out, cpu_irq); end
      fpu_busy = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      xfer(A_STAT, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (ak !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL midrst_idle got ack=%b %h want 1 0000", ak, rd); end
      xfer(A_D4, 1'b0, 16'h0, 2'b11, rd, ak);
      total++; if (rd !== 16'h0000) begin bad++; $display("FAIL midrst_result got %h want 0000", rd); end
   endtask

   initial begin
      ifc.cpu_addr = '0; ifc.cpu_data_in = '0; ifc.cpu_access = 1'b0;
      ifc.cpu_wr_en = 1'b0; ifc.cpu_bytesel = 2'b11;
      test_reset;
      test_dispatch;
      test_nonesc_timeout;
      test_irq;
      test_bytelanes;
      test_window;
      test_back_to_back;
      test_collisions;
      test_reset_midop;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
